// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch unit.
// An entry is {pc[63:32], insn[31:0]}; the FIFO state doubles as its occupancy count.
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC   = 32'h0100_0000;
    localparam logic [31:0] MEM_BYTES  = 32'h0010_0000;
    localparam int          FIFO_DEPTH = 2;

    localparam logic [1:0] FAULT_NONE     = 2'd0;
    localparam logic [1:0] FAULT_MISALIGN = 2'd1;
    localparam logic [1:0] FAULT_RANGE    = 2'd2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        FIFO_EMPTY = 2'd0,
        FIFO_ONE   = 2'd1,
        FIFO_FULL  = 2'd2
    } fifo_state_t;

    function automatic logic word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry skid FIFO whose head always sits in r_mem[0], so the head outputs
// come straight from registers and hold steady while the consumer stalls.
module fetch_skid_fifo
    import fetch_unit_pkg::*;
(
    input  logic         clock,
    input  logic         reset_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_data,
    output fetch_entry_t o_head,
    output logic         o_valid,
    output logic         o_full
);

    fifo_state_t  r_state;
    fetch_entry_t r_mem [FIFO_DEPTH];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= FIFO_EMPTY;
            r_mem[0] <= '0;
            r_mem[1] <= '0;
        end else if (i_flush) begin
            r_state <= FIFO_EMPTY;
        end else begin
            case (r_state)
                FIFO_EMPTY: begin
                    if (i_push) begin
                        r_mem[0] <= i_data;
                        r_state  <= FIFO_ONE;
                    end
                end
                FIFO_ONE: begin
                    if (i_push && i_pop) begin
                        r_mem[0] <= i_data;
                    end else if (i_push) begin
                        r_mem[1] <= i_data;
                        r_state  <= FIFO_FULL;
                    end else if (i_pop) begin
                        r_state <= FIFO_EMPTY;
                    end
                end
                FIFO_FULL: begin
                    // Popping shifts the second entry up; a concurrent push refills the tail.
                    if (i_pop) begin
                        r_mem[0] <= r_mem[1];
                        if (i_push) begin
                            r_mem[1] <= i_data;
                        end else begin
                            r_state <= FIFO_ONE;
                        end
                    end
                end
                default: r_state <= FIFO_EMPTY;
            endcase
        end
    end

    assign o_head  = r_mem[0];
    assign o_valid = (r_state != FIFO_EMPTY);
    assign o_full  = (r_state == FIFO_FULL);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads the combinational instruction memory and
// feeds {pc, insn} to decode through a skid FIFO; redirects flush, bad fetches fault.
module fetch_unit
    import fetch_unit_pkg::fetch_entry_t;
    import fetch_unit_pkg::word_aligned;
    import fetch_unit_pkg::FAULT_NONE;
    import fetch_unit_pkg::FAULT_MISALIGN;
    import fetch_unit_pkg::FAULT_RANGE;
#(
    parameter logic [31:0] RESET_PC  = fetch_unit_pkg::RESET_PC,
    parameter logic [31:0] MEM_BYTES = fetch_unit_pkg::MEM_BYTES
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        fetch_enable,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_address,
    output logic        imem_read_write,
    output logic [31:0] imem_data_in,
    input  logic [31:0] imem_data_out,
    output logic        f_valid,
    input  logic        f_ready,
    output logic [31:0] f_pc,
    output logic [31:0] f_insn,
    output logic        f_fault,
    output logic [1:0]  f_fault_cause,
    output logic [31:0] insn_count
);

    localparam logic [31:0] LAST_PC = RESET_PC + MEM_BYTES - 32'd4;

    // Decode handshake: an entry transfers when f_valid & f_ready; a redirect
    // in the same cycle discards that transfer.
    logic [31:0]  r_pc;
    logic         r_fault;
    logic [1:0]   r_fault_cause;
    logic [31:0]  r_insn_count;

    logic         w_fifo_valid;
    logic         w_fifo_full;
    fetch_entry_t w_fifo_head;
    fetch_entry_t w_push_entry;
    logic         w_pop_req;
    logic         w_pop;
    logic         w_in_range;
    logic         w_push;

    assign w_pop_req  = w_fifo_valid & f_ready;
    assign w_pop      = w_pop_req & ~redirect_valid;
    assign w_in_range = (r_pc >= RESET_PC) && (r_pc <= LAST_PC);
    assign w_push     = fetch_enable & ~redirect_valid & ~r_fault & w_in_range
                      & (~w_fifo_full | w_pop_req);

    assign w_push_entry.pc   = r_pc;
    assign w_push_entry.insn = imem_data_out;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc          <= RESET_PC;
            r_fault       <= 1'b0;
            r_fault_cause <= FAULT_NONE;
            r_insn_count  <= '0;
        end else begin
            if (redirect_valid) begin
                r_pc <= {redirect_pc[31:2], 2'b00};
                if (word_aligned(redirect_pc)) begin
                    r_fault       <= 1'b0;
                    r_fault_cause <= FAULT_NONE;
                end else begin
                    r_fault       <= 1'b1;
                    r_fault_cause <= FAULT_MISALIGN;
                end
            end else begin
                if (w_push) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (!w_in_range && !r_fault) begin
                    r_fault       <= 1'b1;
                    r_fault_cause <= FAULT_RANGE;
                end
            end
            if (w_pop) begin
                r_insn_count <= r_insn_count + 32'd1;
            end
        end
    end

    fetch_skid_fifo u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_data  (w_push_entry),
        .o_head  (w_fifo_head),
        .o_valid (w_fifo_valid),
        .o_full  (w_fifo_full)
    );

    assign imem_address    = r_pc;
    assign imem_read_write = 1'b0;
    assign imem_data_in    = 32'd0;

    assign f_valid       = w_fifo_valid;
    assign f_pc          = w_fifo_head.pc;
    assign f_insn        = w_fifo_head.insn;
    assign f_fault       = r_fault;
    assign f_fault_cause = r_fault_cause;
    assign insn_count    = r_insn_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a linear sequence of steps with hand-computed
// expectations, each checked by an immediate assertion.
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        fetch_enable;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_address;
    logic        imem_read_write;
    logic [31:0] imem_data_in;
    logic [31:0] imem_data_out;
    logic        f_valid;
    logic        f_ready;
    logic [31:0] f_pc;
    logic [31:0] f_insn;
    logic        f_fault;
    logic [1:0]  f_fault_cause;
    logic [31:0] insn_count;

    int checks = 0;
    int errors = 0;

    // Clock / reset
    always #5 clock = ~clock;

    // Memory word at byte address a is 0xA0 + word index from the base.
    assign imem_data_out = 32'hA0 + ((imem_address - 32'h0100_0000) >> 2);

    fetch_unit dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .fetch_enable    (fetch_enable),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_address    (imem_address),
        .imem_read_write (imem_read_write),
        .imem_data_in    (imem_data_in),
        .imem_data_out   (imem_data_out),
        .f_valid         (f_valid),
        .f_ready         (f_ready),
        .f_pc            (f_pc),
        .f_insn          (f_insn),
        .f_fault         (f_fault),
        .f_fault_cause   (f_fault_cause),
        .insn_count      (insn_count)
    );

    // Driver tasks
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] insn,
                              input logic [31:0] cnt);
        check({tag, "_valid"}, {31'd0, f_valid}, 32'd1);
        check({tag, "_pc"}, f_pc, pc);
        check({tag, "_insn"}, f_insn, insn);
        check({tag, "_count"}, insn_count, cnt);
    endtask

    initial begin
        reset_n        = 1'b0;
        fetch_enable   = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        f_ready        = 1'b0;
        step();
        step();

        // Reset state
        check("rst_valid", {31'd0, f_valid}, 32'd0);
        check("rst_pc", f_pc, 32'd0);
        check("rst_insn", f_insn, 32'd0);
        check("rst_fault", {31'd0, f_fault}, 32'd0);
        check("rst_cause", {30'd0, f_fault_cause}, 32'd0);
        check("rst_count", insn_count, 32'd0);
        check("rst_addr", imem_address, 32'h0100_0000);
        check("rst_rw", {31'd0, imem_read_write}, 32'd0);
        check("rst_din", imem_data_in, 32'd0);

        // Streaming with decode always ready
        reset_n      = 1'b1;
        fetch_enable = 1'b1;
        f_ready      = 1'b1;
        step();
        check_head("s0", 32'h0100_0000, 32'hA0, 32'd0);
        step();
        check_head("s1", 32'h0100_0004, 32'hA1, 32'd1);
        step();
        check_head("s2", 32'h0100_0008, 32'hA2, 32'd2);
        step();
        check("s3_count", insn_count, 32'd3);

        // Backpressure from a fresh reset: FIFO fills, pc holds
        reset_n = 1'b0;
        #1;
        check("async_clr_count", insn_count, 32'd0);
        f_ready = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        step();
        step();
        step();
        step();
        step();
        check_head("bp_hold", 32'h0100_0000, 32'hA0, 32'd0);
        check("bp_addr", imem_address, 32'h0100_0008);
        f_ready = 1'b1;
        step();
        check_head("bp_d0", 32'h0100_0004, 32'hA1, 32'd1);
        step();
        check_head("bp_d1", 32'h0100_0008, 32'hA2, 32'd2);

        // Redirect while full with decode ready: flush and no count
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0100_0100;
        step();
        redirect_valid = 1'b0;
        check("rd_valid", {31'd0, f_valid}, 32'd0);
        check("rd_count", insn_count, 32'd2);
        check("rd_addr", imem_address, 32'h0100_0100);
        step();
        check_head("rd_first", 32'h0100_0100, 32'hE0, 32'd2);
        step();
        check_head("rd_second", 32'h0100_0104, 32'hE1, 32'd3);

        // Misaligned redirect faults and stops fetching
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0100_0102;
        step();
        redirect_valid = 1'b0;
        check("mis_fault", {31'd0, f_fault}, 32'd1);
        check("mis_cause", {30'd0, f_fault_cause}, 32'd1);
        check("mis_valid", {31'd0, f_valid}, 32'd0);
        check("mis_addr", imem_address, 32'h0100_0100);
        step();
        step();
        check("mis_nopush", {31'd0, f_valid}, 32'd0);
        check("mis_pc_hold", imem_address, 32'h0100_0100);

        // Aligned redirect clears the fault and resumes
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0100_0200;
        step();
        redirect_valid = 1'b0;
        check("clr_fault", {31'd0, f_fault}, 32'd0);
        check("clr_cause", {30'd0, f_fault_cause}, 32'd0);
        step();
        check_head("clr_resume", 32'h0100_0200, 32'h120, 32'd3);
        step();
        check("clr_count", insn_count, 32'd4);

        // Last in-range word, then range fault; stored entry still drains
        redirect_valid = 1'b1;
        redirect_pc    = 32'h010F_FFFC;
        step();
        redirect_valid = 1'b0;
        f_ready        = 1'b0;
        check("rng_flush", {31'd0, f_valid}, 32'd0);
        step();
        check_head("rng_last", 32'h010F_FFFC, 32'h0004_009F, 32'd4);
        check("rng_nofault", {31'd0, f_fault}, 32'd0);
        check("rng_addr", imem_address, 32'h0110_0000);
        step();
        check("rng_fault", {31'd0, f_fault}, 32'd1);
        check("rng_cause", {30'd0, f_fault_cause}, 32'd2);
        check("rng_kept", {31'd0, f_valid}, 32'd1);
        f_ready = 1'b1;
        step();
        check("rng_drain_count", insn_count, 32'd5);
        check("rng_drain_valid", {31'd0, f_valid}, 32'd0);
        check("rng_pc_hold", imem_address, 32'h0110_0000);
        check("rng_sticky", {31'd0, f_fault}, 32'd1);

        // Full FIFO plus range fault, then asynchronous reset
        redirect_valid = 1'b1;
        redirect_pc    = 32'h010F_FFF8;
        f_ready        = 1'b0;
        step();
        redirect_valid = 1'b0;
        step();
        step();
        step();
        check_head("pre_rst", 32'h010F_FFF8, 32'h0004_009E, 32'd5);
        check("pre_rst_fault", {31'd0, f_fault}, 32'd1);
        reset_n = 1'b0;
        #2;
        check("arst_valid", {31'd0, f_valid}, 32'd0);
        check("arst_fault", {31'd0, f_fault}, 32'd0);
        check("arst_cause", {30'd0, f_fault_cause}, 32'd0);
        check("arst_count", insn_count, 32'd0);
        fetch_enable = 1'b0;
        f_ready      = 1'b1;
        step();
        reset_n = 1'b1;
        check("arst_addr", imem_address, 32'h0100_0000);

        // Stall: fetch_enable low holds pc and suppresses pushes
        step();
        step();
        check("stall_valid", {31'd0, f_valid}, 32'd0);
        check("stall_addr", imem_address, 32'h0100_0000);
        fetch_enable = 1'b1;
        step();
        check_head("post_stall", 32'h0100_0000, 32'hA0, 32'd0);

        // Final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Initiator side of the instruction-memory interface. Owns the PC and drives word addresses into the byte-addressed, combinational-read instruction memory.
- Captures each returned word with its PC into a 2-entry skid FIFO. Hands {pc, insn} to decode with a valid/ready handshake.
- Handles redirects (branch/jump) and stalls without losing or duplicating instructions. Raises a sticky fault on a misaligned or out-of-range fetch.

Parameters:
- RESET_PC, 32'h0100_0000, first fetch address; also the memory base address.
- MEM_BYTES, 32'h0010_0000, size of the instruction memory window in bytes.
- FIFO_DEPTH, 2, skid FIFO entries (fixed at 2; anything else is unsupported).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- fetch_enable  in  1  1 = fetch may advance; 0 = PC holds, no pushes.
- redirect_valid  in  1  single-cycle request to load a new PC.
- redirect_pc  in  32  new fetch target.
- imem_address  out  32  byte address to memory; equals pc.
- imem_read_write  out  1  tied 0 (read).
- imem_data_in  out  32  tied 0.
- imem_data_out  in  32  instruction word, valid combinationally in the same cycle as imem_address.
- f_valid  out  1  head FIFO entry is valid.
- f_ready  in  1  decode accepts the head entry.
- f_pc  out  32  PC of the head entry.
- f_insn  out  32  instruction of the head entry.
- f_fault  out  1  sticky fetch fault.
- f_fault_cause  out  2  0 = none, 1 = misaligned, 2 = out of range.
- insn_count  out  32  count of entries handed to decode.

Behaviour:
Reset (asynchronous, active-low):
- pc = RESET_PC; FIFO count = 0.
- f_valid = 0; f_pc = 0; f_insn = 0.
- f_fault = 0; f_fault_cause = 0; insn_count = 0.
- On deassertion, the first push happens on the first rising edge with fetch_enable = 1.

Definitions:
- pop = f_valid & f_ready.
- in_range = (pc >= RESET_PC) & (pc <= RESET_PC + MEM_BYTES - 4).
- push = fetch_enable & !redirect_valid & !f_fault & in_range & (count < 2 | pop).

Push:
- Writes {pc, imem_data_out} at the FIFO tail; pc <= pc + 4 (32-bit, wraps).
- Latency: the entry appears on f_* the cycle after the push.

Pop and handshake:
- Pop advances the head. insn_count increments by 1 per pop, wrapping at 2^32.
- Push and pop in the same cycle are allowed at any count, including full.
- f_pc, f_insn and f_valid are driven from registers and stay stable while f_valid & !f_ready.

Redirect (highest priority):
- Flushes the FIFO (count = 0) and discards any pop that cycle; insn_count does not increment.
- pc <= {redirect_pc[31:2], 2'b00}. No push that cycle.
- If redirect_pc[1:0] != 0: f_fault <= 1, f_fault_cause <= 1.
- Otherwise f_fault and f_fault_cause clear to 0. Redirect is the only way to clear a fault besides reset.

Out of range:
- When !in_range and !f_fault and !redirect_valid: f_fault <= 1, f_fault_cause <= 2, no push.
- Entries already in the FIFO still drain normally.

Stall:
- fetch_enable = 0 holds pc and suppresses pushes. Pops still proceed.

FIFO state encoding: EMPTY (count 0), ONE (1), FULL (2).
- EMPTY→ONE on push.
- ONE→FULL on push without pop.
- FULL→ONE on pop without push.
- ONE→EMPTY on pop without push.
- Any state→EMPTY on redirect.
- Push with pop leaves the count unchanged.

Decomposition:
- Shared defines header: RESET_PC, MEM_BYTES, the fault cause codes (FAULT_NONE, FAULT_MISALIGN, FAULT_RANGE), and the 64-bit entry layout {pc[63:32], insn[31:0]}.
- One natural sub-module: fetch_skid_fifo, a 2-entry, 64-bit-wide FIFO.
  - Inputs: push, pop, flush.
  - Outputs: head, valid, full.
  - Same clock and reset_n as the parent.

Test Plan:
- Reset release, fetch_enable = 1, f_ready = 1, memory words 0xA0, 0xA1, 0xA2 → f_pc = 0x01000000, 0x01000004, 0x01000008 on consecutive cycles starting cycle 2; insn_count = 3 after three pops.
- f_ready = 0 for 4 cycles → FIFO fills with 2 entries and pc holds at 0x01000008. Raise f_ready → 0x01000000 and 0x01000004 appear in order, with no gap or duplicate.
- redirect_valid with redirect_pc = 0x01000100 while FIFO is full and f_ready = 1 → f_valid = 0 the next cycle; the next f_pc = 0x01000100; insn_count unchanged on the redirect cycle.
- redirect_pc = 0x01000102 → f_fault = 1, f_fault_cause = 1, no further pushes. A following redirect to 0x01000200 → fault clears and fetch resumes at 0x01000200.
- Redirect to RESET_PC + MEM_BYTES - 4 → one push, then f_fault = 1 with f_fault_cause = 2; pc stays at RESET_PC + MEM_BYTES.
- Assert reset_n = 0 mid-stream with a full FIFO → f_valid, f_fault and insn_count clear immediately (asynchronously); pc = 0x01000000 after release.
